// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: states, widths and ALU FunSel codes shared by the ALU arbiter
package alu_arb_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int DATA_W   = 32;
    localparam int FUNSEL_W = 5;
    localparam int FLAG_W   = 4;
    localparam logic [4:0] FS_ADD32 = 5'b10100;
    localparam logic [4:0] FS_ADC32 = 5'b10101;
    localparam logic [4:0] FS_SUB32 = 5'b10110;
endpackage

// File: rtl/alu_arb_rr_picker.sv
// alu_arb_rr_picker: two-way round-robin pick, masked to the owner while locked
module alu_arb_rr_picker (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       locked,
    input  logic       owner,
    output logic [1:0] gnt,
    output logic       win
);
    logic [1:0] elig;
    always_comb begin
        elig = locked ? (req & (owner ? 2'b10 : 2'b01)) : req;
        win  = (elig == 2'b11) ? ptr : elig[1];
        gnt  = (elig == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin grant and lock
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_W,
    parameter int FUNSEL_WIDTH = FUNSEL_W,
    parameter int FLAG_WIDTH   = FLAG_W,
    parameter int MAX_LOCK_OPS = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    R0_Req,
    input  logic                    R0_Lock,
    input  logic [FUNSEL_WIDTH-1:0] R0_FunSel,
    input  logic [DATA_WIDTH-1:0]   R0_A,
    input  logic [DATA_WIDTH-1:0]   R0_B,
    input  logic                    R0_WF,
    output logic                    R0_Gnt,
    output logic                    R0_Done,
    output logic [DATA_WIDTH-1:0]   R0_Result,
    output logic [FLAG_WIDTH-1:0]   R0_Flags,
    input  logic                    R1_Req,
    input  logic                    R1_Lock,
    input  logic [FUNSEL_WIDTH-1:0] R1_FunSel,
    input  logic [DATA_WIDTH-1:0]   R1_A,
    input  logic [DATA_WIDTH-1:0]   R1_B,
    input  logic                    R1_WF,
    output logic                    R1_Gnt,
    output logic                    R1_Done,
    output logic [DATA_WIDTH-1:0]   R1_Result,
    output logic [FLAG_WIDTH-1:0]   R1_Flags,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [FUNSEL_WIDTH-1:0] ALU_FunSel,
    output logic                    ALU_WF,
    input  logic [DATA_WIDTH-1:0]   ALU_Out,
    input  logic [FLAG_WIDTH-1:0]   ALU_Flags
);
    localparam int CW = $clog2(MAX_LOCK_OPS + 1);
    state_t state, state_nx;
    logic ptr, locked, owner, wf_q, arb, rel, hold, win;
    logic [CW-1:0] cnt;
    logic [FUNSEL_WIDTH-1:0] fs_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [1:0] req, lck, gnt;

    assign req  = {R1_Req, R0_Req};
    assign lck  = {R1_Lock, R0_Lock};
    assign arb  = (state != EXEC) && !Reset;
    // the lock survives a dropped Req only while the owner keeps Lock asserted
    assign rel  = (cnt == CW'(MAX_LOCK_OPS)) || (!req[owner] && !lck[owner]);
    assign hold = locked && !rel;

    alu_arb_rr_picker u_pick (
        .req(req), .ptr(ptr), .locked(hold), .owner(owner), .gnt(gnt), .win(win)
    );

    assign R0_Gnt     = arb && gnt[0];
    assign R1_Gnt     = arb && gnt[1];
    assign R0_Done    = (state == RESP) && !owner;
    assign R1_Done    = (state == RESP) && owner;
    assign R0_Flags   = ALU_Flags;
    assign R1_Flags   = ALU_Flags;
    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign ALU_FunSel = fs_q;
    assign ALU_WF     = (state == EXEC) && wf_q;

    always_comb begin
        state_nx = IDLE;
        state_nx = (state == EXEC) ? RESP : ((gnt != 2'b00) ? EXEC : IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            locked    <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            wf_q      <= 1'b0;
            fs_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            R0_Result <= '0;
            R1_Result <= '0;
        end else begin
            state <= state_nx;
            if (state == EXEC) begin
                if (owner) R1_Result <= ALU_Out;
                else R0_Result <= ALU_Out;
            end else if (gnt != 2'b00) begin
                ptr    <= ~win;
                owner  <= win;
                fs_q   <= win ? R1_FunSel : R0_FunSel;
                a_q    <= win ? R1_A : R0_A;
                b_q    <= win ? R1_B : R0_B;
                wf_q   <= win ? R1_WF : R0_WF;
                locked <= lck[win];
                cnt    <= lck[win] ? (hold ? cnt + 1'b1 : CW'(1)) : '0;
            end else if (locked && rel) begin
                locked <= 1'b0;
                cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter with a bench-side ALU
module tb_alu_arbiter;
    import alu_arb_pkg::*;
    localparam int MAXL = 4;
    typedef struct packed {logic [4:0] fs; logic [31:0] a; logic [31:0] b; logic wf; logic lock;} op_t;
    typedef struct packed {logic k; logic [31:0] res; logic [3:0] fl;} exp_t;

    logic Clock = 0, Reset = 1;
    logic req [2], lock [2], wf [2];
    logic [4:0] fs [2];
    logic [31:0] a [2], b [2];
    logic gnt0, gnt1, dn0, dn1, alu_wf;
    logic [31:0] res0, res1, alu_a, alu_b, alu_out;
    logic [3:0] fl0, fl1, alu_flags = 4'b0000;
    logic [4:0] alu_fs;
    logic [35:0] alu_r;
    int nchk = 0, nerr = 0;
    op_t q0[$], q1[$];
    exp_t sb[$];
    bit gs [2];
    bit drop_en = 0;

    alu_arbiter #(.MAX_LOCK_OPS(MAXL)) dut (
        .Clock(Clock), .Reset(Reset),
        .R0_Req(req[0]), .R0_Lock(lock[0]), .R0_FunSel(fs[0]), .R0_A(a[0]), .R0_B(b[0]), .R0_WF(wf[0]),
        .R0_Gnt(gnt0), .R0_Done(dn0), .R0_Result(res0), .R0_Flags(fl0),
        .R1_Req(req[1]), .R1_Lock(lock[1]), .R1_FunSel(fs[1]), .R1_A(a[1]), .R1_B(b[1]), .R1_WF(wf[1]),
        .R1_Gnt(gnt1), .R1_Done(dn1), .R1_Result(res1), .R1_Flags(fl1),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FunSel(alu_fs), .ALU_WF(alu_wf),
        .ALU_Out(alu_out), .ALU_Flags(alu_flags)
    );

    always #5 Clock = ~Clock;

    // flags are {Z,C,N,O}; SUB carry means "no borrow"
    function automatic logic [35:0] alu_calc(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] s;
        logic o;
        if (f == FS_ADC32) s = {1'b0, x} + {1'b0, y} + 33'(ci);
        else if (f == FS_SUB32) s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        else s = {1'b0, x} + {1'b0, y};
        o = (f == FS_SUB32) ? (x[31] != y[31] && s[31] != x[31]) : (x[31] == y[31] && s[31] != x[31]);
        return {s[31:0] == 32'd0, s[32], s[31], o, s[31:0]};
    endfunction

    always_comb alu_r = alu_calc(alu_fs, alu_a, alu_b, alu_flags[2]);
    assign alu_out = alu_r[31:0];
    always @(posedge Clock) if (alu_wf) alu_flags <= alu_r[35:32];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        gs[0] = gnt0;
        gs[1] = gnt1;
    end

    // requester driver: holds the head op of each queue until it is granted
    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; lock[k] = 0; wf[k] = 0; fs[k] = 0; a[k] = 0; b[k] = 0;
        end
        forever begin
            @(posedge Clock); #1;
            for (int k = 0; k < 2; k++) begin
                op_t o;
                bit has;
                o = '0;
                if (gs[k]) begin
                    if (k == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
                has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (has) begin
                    o = (k == 0) ? q0[0] : q1[0];
                    fs[k] = o.fs; a[k] = o.a; b[k] = o.b; wf[k] = o.wf;
                end
                req[k]  = has && !(drop_en && $urandom_range(0, 3) == 0);
                lock[k] = has && o.lock;
            end
        end
    end

    // reference model: timestamps of the last grant plus lock owner/count bookkeeping
    int cyc = 0, lg = -10, lo = -1, lcnt = 0, lown = 0;
    bit ptr = 0, lwf = 0;
    logic [3:0] mfl = 4'b0000, mfl_prev = 4'b0000;

    always @(negedge Clock) begin
        int w;
        bit e0, e1;
        logic [35:0] r;
        if (Reset) begin
            if (cyc == lg + 1) begin
                mfl = mfl_prev;
                if (sb.size() > 0) void'(sb.pop_back());
            end
            cyc = 0; lg = -10; lo = -1; lcnt = 0; ptr = 0;
        end else begin
            w = -1;
            if (cyc != lg + 1) begin
                if (lo >= 0 && (lcnt == MAXL || (!req[lo] && !lock[lo]))) begin
                    lo = -1;
                    lcnt = 0;
                end
                e0 = req[0] && lo != 1;
                e1 = req[1] && lo != 0;
                w = (e0 && e1) ? int'(ptr) : e0 ? 0 : e1 ? 1 : -1;
            end
            chk("gnt0", gnt0, w == 0);
            chk("gnt1", gnt1, w == 1);
            chk("alu_wf", alu_wf, cyc == lg + 1 && lwf);
            chk("done0", dn0, cyc == lg + 2 && lown == 0);
            chk("done1", dn1, cyc == lg + 2 && lown == 1);
            if (w >= 0) begin
                r = alu_calc(fs[w], a[w], b[w], mfl[2]);
                sb.push_back(exp_t'{k: w[0], res: r[31:0], fl: wf[w] ? r[35:32] : mfl});
                mfl_prev = mfl;
                if (wf[w]) mfl = r[35:32];
                if (lock[w]) begin
                    lcnt = (lo == w) ? lcnt + 1 : 1;
                    lo = w;
                end else begin
                    lo = -1;
                    lcnt = 0;
                end
                ptr = (w == 0); lg = cyc; lown = w; lwf = wf[w];
            end
            cyc++;
        end
    end

    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) for (int k = 0; k < 2; k++) if (k == 1 ? dn1 : dn0) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL spurious_done%0d: got Done with no op outstanding, expected none", k);
            end else begin
                e = sb.pop_front();
                chk("done_owner", 64'(k), 64'(e.k));
                chk(k == 1 ? "result1" : "result0", k == 1 ? res1 : res0, e.res);
                chk(k == 1 ? "flags1" : "flags0", k == 1 ? fl1 : fl0, e.fl);
            end
        end
    end

    task automatic push(input int k, input logic [4:0] f, input logic [31:0] x, input logic [31:0] y, input logic w, input logic l);
        op_t o;
        o = '{fs: f, a: x, b: y, wf: w, lock: l};
        if (k == 0) q0.push_back(o);
        else q1.push_back(o);
    endtask

    function automatic logic [4:0] rfs();
        int s;
        s = $urandom_range(0, 2);
        return s == 0 ? FS_ADD32 : s == 1 ? FS_ADC32 : FS_SUB32;
    endfunction

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 300) begin
            @(posedge Clock);
            n++;
        end
        repeat (3) @(posedge Clock);
        chk(nm, n < 300, 1);
    endtask

    initial begin
        int n;
        #22;
        chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
        chk("rst_done0", dn0, 0); chk("rst_done1", dn1, 0);
        chk("rst_alu_wf", alu_wf, 0); chk("rst_res0", res0, 0); chk("rst_res1", res1, 0);
        chk("rst_alu_a", alu_a, 0); chk("rst_alu_b", alu_b, 0); chk("rst_alu_fs", alu_fs, 0);
        @(posedge Clock); #3 Reset = 0;

        push(0, FS_ADD32, 32'd5, 32'd3, 1, 0);
        drain("t1_timeout");
        chk("t1_res0", res0, 32'd8);
        chk("t1_flags0", fl0, 4'b0000);

        for (int i = 0; i < 4; i++) begin
            push(0, FS_ADD32, $urandom, $urandom, 1, 0);
            push(1, FS_SUB32, $urandom, $urandom, 1, 0);
        end
        drain("t2_timeout");

        push(1, FS_ADD32, 32'hFFFF_FFFF, 32'd1, 1, 1);
        push(1, FS_ADC32, 32'd0, 32'd0, 1, 0);
        push(0, FS_SUB32, 32'd9, 32'd4, 1, 0);
        drain("t3_timeout");
        chk("t3_res1", res1, 32'd1);

        for (int i = 0; i < 6; i++) push(0, FS_ADD32, $urandom, $urandom, 1, 1);
        for (int i = 0; i < 2; i++) push(1, FS_ADD32, $urandom, $urandom, 1, 0);
        drain("t4_timeout");

        push(0, FS_ADD32, 32'h7FFF_FFFF, 32'd1, 1, 0);
        push(1, FS_ADD32, 32'd2, 32'd2, 1, 0);
        n = 0;
        while (!gs[0] && n < 50) begin
            @(negedge Clock); #1;
            n++;
        end
        chk("t5_gnt_seen", n < 50, 1);
        @(posedge Clock); #3 Reset = 1; #1;
        chk("t5_gnt0", gnt0, 0); chk("t5_gnt1", gnt1, 0);
        chk("t5_done0", dn0, 0); chk("t5_done1", dn1, 0); chk("t5_alu_wf", alu_wf, 0);
        push(0, FS_SUB32, 32'd7, 32'd7, 1, 0);
        push(1, FS_ADD32, 32'd1, 32'd1, 1, 0);
        repeat (2) @(posedge Clock);
        #3 Reset = 0;
        drain("t5_timeout");

        push(0, FS_ADD32, 32'hFFFF_FFFF, 32'd1, 1, 0);
        push(0, FS_ADD32, 32'd0, 32'd0, 0, 0);
        drain("t6_timeout");
        chk("t6_flags0", fl0, 4'b1100);
        chk("t6_res0", res0, 32'd0);

        drop_en = 1;
        repeat (400) begin
            @(posedge Clock);
            if (q0.size() < 3 && $urandom_range(0, 2) == 0)
                push(0, rfs(), $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom, $urandom, 1'($urandom), $urandom_range(0, 3) == 0);
            if (q1.size() < 3 && $urandom_range(0, 2) == 0)
                push(1, rfs(), $urandom, $urandom_range(0, 3) == 0 ? 32'd1 : $urandom, 1'($urandom), $urandom_range(0, 3) == 0);
        end
        drop_en = 0;
        drain("t7_timeout");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
